rcs4_seq: RTL

Sequential ripple-borrow subtractor, the inverse-direction companion to the team's 4-bit ripple-carry adder. It computes A − B − Bin one bit-slice per clock with a start/busy/done handshake, reusing the same operand/carry-style port arrangement. The results close the loop against the combinational adder in the arithmetic test harness: Diff + B + Bin reproduces A. The block is the serial, area-minimal subtraction path for the VLSI datapath exercises.

---
 rtl/rcs4_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rcs4_seq.sv
// rtl/rcs4_seq.sv - bit-serial ripple-borrow subtractor, A - B - Bin; optional SUB_OVF_EN adds ovf_o
module rcs4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             slice_d;
  logic             slice_br;
`ifdef SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One bit-slice of the ripple-borrow chain, fed from the LSBs of the operand shifters
  always_comb begin
    slice_d  = a_q[0] ^ b_q[0] ^ br_q;
    slice_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Next-state and next-output logic; busy/done are computed here and registered
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = bin_i;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB so slice 0 lands at bit 0 after WIDTH shifts
        res_d  = {slice_d, res_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = slice_br;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = {slice_d, res_q[WIDTH-1:1]};
          bout_d  = slice_br;
`ifdef SUB_OVF_EN
          // br_q is the borrow into the MSB slice at this point
          ovf_d   = br_q ^ slice_br;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
`ifdef SUB_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule
